// File: rtl/stack_pkg.sv
// Constants and FSM state encoding shared by the return-stack call/return sequencer
// and the hardware return stack it drives.
package stack_pkg;
    localparam int DATA_W = 18;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PUSH = 3'd1,
        POP  = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;
endpackage

// File: rtl/stack_depth_tracker.sv
// Occupancy counter for the return stack; refuses to count past full or below empty.
module stack_depth_tracker
    import stack_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] depth,
    output logic             full,
    output logic             empty
);
    logic [CNT_W-1:0] depth_q;
    logic [CNT_W-1:0] depth_d;

    assign full  = (depth_q == CNT_W'(DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;

    always_comb begin
        depth_d = depth_q;
        if (inc && !dec && !full) begin
            depth_d = depth_q + CNT_W'(1);
        end else if (dec && !inc && !empty) begin
            depth_d = depth_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end
endmodule

// File: rtl/stack_call_ctrl.sv
// Call/return sequencer for the 4-entry hardware return stack: bounds-checks pushes and
// pops, drives the stack enables, and hands the popped address back with a valid pulse.
//
// Handshake: a request (call_req or ret_req) is taken on a rising edge where req_ready=1;
// call wins over a simultaneous ret; requests seen while req_ready=0 are ignored, not queued.
module stack_call_ctrl
    import stack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              call_req,
    input  logic              ret_req,
    input  logic [DATA_W-1:0] ret_addr_in,
    output logic              req_ready,
    output logic [DATA_W-1:0] stk_wr_data,
    output logic              stk_wr_en,
    output logic              stk_rd_en,
    input  logic [DATA_W-1:0] stk_rd_data,
    output logic              ret_valid,
    output logic [DATA_W-1:0] ret_addr,
    output logic [CNT_W-1:0]  depth,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr,
    output logic [2:0]        state_dbg
);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DATA_W-1:0] ret_addr_q, ret_addr_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              ret_valid_q, ret_valid_d;
    logic              ready_q, ready_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              inc, dec, ovf_set, unf_set;
    logic              full, empty;

    stack_depth_tracker u_depth (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc),
        .dec   (dec),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d    = state_q;
        wr_data_d  = wr_data_q;
        ret_addr_d = ret_addr_q;
        inc        = 1'b0;
        dec        = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        case (state_q)
            IDLE: begin
                if (call_req) begin
                    if (!full) begin
                        wr_data_d = ret_addr_in;
                        inc       = 1'b1;
                        state_d   = PUSH;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end else if (ret_req) begin
                    if (!empty) begin
                        dec     = 1'b1;
                        state_d = POP;
                    end else begin
                        unf_set = 1'b1;
                    end
                end
            end
            PUSH: state_d = IDLE;
            POP:  state_d = WAIT;
            WAIT: begin
                // Stack registered its output at the end of POP; it is stable here.
                ret_addr_d = stk_rd_data;
                state_d    = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so every output comes straight off a flop.
        wr_en_d     = (state_d == PUSH);
        rd_en_d     = (state_d == POP);
        ret_valid_d = (state_d == DONE);
        ready_d     = (state_d == IDLE);
        ovf_d       = err_clr ? 1'b0 : (ovf_q | ovf_set);
        unf_d       = err_clr ? 1'b0 : (unf_q | unf_set);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_data_q   <= '0;
            ret_addr_q  <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            ret_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_data_q   <= wr_data_d;
            ret_addr_q  <= ret_addr_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            ret_valid_q <= ret_valid_d;
            ready_q     <= ready_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign req_ready   = ready_q;
    assign stk_wr_data = wr_data_q;
    assign stk_wr_en   = wr_en_q;
    assign stk_rd_en   = rd_en_q;
    assign ret_valid   = ret_valid_q;
    assign ret_addr    = ret_addr_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign state_dbg   = state_q;
endmodule

// File: tb/tb_stack_call_ctrl.sv
// Bench for stack_call_ctrl: a behavioural return stack on the far side, table-driven
// directed vectors, hand-written corner sequences and a randomized queue-model phase.
module tb_stack_call_ctrl;
    localparam int W      = 18;
    localparam int K_PUSH = 0;
    localparam int K_POP  = 1;
    localparam int K_NONE = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          call_req, ret_req, err_clr;
    logic [W-1:0]  ret_addr_in;
    logic          req_ready, stk_wr_en, stk_rd_en, ret_valid, overflow, underflow;
    logic [W-1:0]  stk_wr_data, stk_rd_data, ret_addr;
    logic [2:0]    depth;
    logic [2:0]    state_dbg;

    stack_call_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .call_req    (call_req),
        .ret_req     (ret_req),
        .ret_addr_in (ret_addr_in),
        .req_ready   (req_ready),
        .stk_wr_data (stk_wr_data),
        .stk_wr_en   (stk_wr_en),
        .stk_rd_en   (stk_rd_en),
        .stk_rd_data (stk_rd_data),
        .ret_valid   (ret_valid),
        .ret_addr    (ret_addr),
        .depth       (depth),
        .overflow    (overflow),
        .underflow   (underflow),
        .err_clr     (err_clr),
        .state_dbg   (state_dbg)
    );

    // behavioural hardware return stack: unchecked 2-bit SP, registered pop output
    logic [W-1:0] stk_mem [4];
    logic [1:0]   stk_sp;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stk_sp      <= 2'd0;
            stk_rd_data <= '0;
        end else if (stk_wr_en) begin
            stk_mem[stk_sp] <= stk_wr_data;
            stk_sp          <= stk_sp + 2'd1;
        end else if (stk_rd_en) begin
            stk_rd_data <= stk_mem[stk_sp - 2'd1];
            stk_sp      <= stk_sp - 2'd1;
        end
    end

    // scoreboard
    int n_cmp  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic do_op(input bit c, input bit r, input bit clr, input logic [W-1:0] a,
                         input int kind, input logic [W-1:0] er, input logic [2:0] ed,
                         input bit eo, input bit eu);
        wait_ready();
        call_req    = c;
        ret_req     = r;
        err_clr     = clr;
        ret_addr_in = a;
        @(posedge clk);
        #1;
        call_req = 1'b0;
        ret_req  = 1'b0;
        err_clr  = 1'b0;
        @(negedge clk);
        chk("overflow", 32'(overflow), 32'(eo));
        chk("underflow", 32'(underflow), 32'(eu));
        chk("depth", 32'(depth), 32'(ed));
        if (kind == K_PUSH) begin
            chk("push_wr_en", 32'(stk_wr_en), 32'd1);
            chk("push_rd_en", 32'(stk_rd_en), 32'd0);
            chk("push_ready", 32'(req_ready), 32'd0);
            chk("push_data", 32'(stk_wr_data), 32'(a));
            @(negedge clk);
            chk("push_end_wr_en", 32'(stk_wr_en), 32'd0);
            chk("push_end_ready", 32'(req_ready), 32'd1);
        end else if (kind == K_POP) begin
            exp_q.push_back(er);
            chk("pop_rd_en", 32'(stk_rd_en), 32'd1);
            chk("pop_wr_en", 32'(stk_wr_en), 32'd0);
            chk("pop_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            chk("wait_valid", 32'(ret_valid), 32'd0);
            chk("wait_rd_en", 32'(stk_rd_en), 32'd0);
            @(negedge clk);
            chk("done_valid", 32'(ret_valid), 32'd1);
            if (ret_valid && exp_q.size() > 0) chk("ret_addr", 32'(ret_addr), 32'(exp_q.pop_front()));
            @(negedge clk);
            chk("post_valid", 32'(ret_valid), 32'd0);
            chk("post_ready", 32'(req_ready), 32'd1);
            chk("ret_addr_hold", 32'(ret_addr), 32'(er));
        end else begin
            chk("none_wr_en", 32'(stk_wr_en), 32'd0);
            chk("none_rd_en", 32'(stk_rd_en), 32'd0);
            chk("none_ready", 32'(req_ready), 32'd1);
            @(negedge clk);
            chk("none_valid", 32'(ret_valid), 32'd0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_wr_en"}, 32'(stk_wr_en), 32'd0);
        chk({tag, "_rd_en"}, 32'(stk_rd_en), 32'd0);
        chk({tag, "_wr_data"}, 32'(stk_wr_data), 32'd0);
        chk({tag, "_ret_addr"}, 32'(ret_addr), 32'd0);
        chk({tag, "_ret_valid"}, 32'(ret_valid), 32'd0);
        chk({tag, "_depth"}, 32'(depth), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_underflow"}, 32'(underflow), 32'd0);
    endtask

    typedef struct {
        bit           c;
        bit           r;
        bit           clr;
        logic [W-1:0] a;
        int           kind;
        logic [W-1:0] er;
        logic [2:0]   ed;
        bit           eo;
        bit           eu;
    } vec_t;

    vec_t tbl[$];

    // higher-level reference: a queue of addresses plus two sticky flags
    logic [W-1:0] model_stk[$];
    bit           m_ovf, m_unf;

    initial begin
        call_req    = 1'b0;
        ret_req     = 1'b0;
        err_clr     = 1'b0;
        ret_addr_in = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        //            c  r  clr addr      kind    exp_ret   d  ovf unf
        tbl.push_back('{1, 0, 0, 18'h00010, K_PUSH, 18'h0,     1, 0, 0});
        tbl.push_back('{1, 0, 0, 18'h00020, K_PUSH, 18'h0,     2, 0, 0});
        tbl.push_back('{1, 0, 0, 18'h00030, K_PUSH, 18'h0,     3, 0, 0});
        tbl.push_back('{1, 0, 0, 18'h00040, K_PUSH, 18'h0,     4, 0, 0});
        tbl.push_back('{0, 1, 0, 18'h0,     K_POP,  18'h00040, 3, 0, 0});
        tbl.push_back('{0, 1, 0, 18'h0,     K_POP,  18'h00030, 2, 0, 0});
        tbl.push_back('{0, 1, 0, 18'h0,     K_POP,  18'h00020, 1, 0, 0});
        tbl.push_back('{0, 1, 0, 18'h0,     K_POP,  18'h00010, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 18'h00010, K_PUSH, 18'h0,     1, 0, 0});
        tbl.push_back('{1, 0, 0, 18'h00020, K_PUSH, 18'h0,     2, 0, 0});
        tbl.push_back('{1, 0, 0, 18'h00030, K_PUSH, 18'h0,     3, 0, 0});
        tbl.push_back('{1, 0, 0, 18'h00040, K_PUSH, 18'h0,     4, 0, 0});
        tbl.push_back('{1, 0, 0, 18'h3FFFF, K_NONE, 18'h0,     4, 1, 0});
        tbl.push_back('{0, 1, 0, 18'h0,     K_POP,  18'h00040, 3, 1, 0});
        tbl.push_back('{0, 1, 0, 18'h0,     K_POP,  18'h00030, 2, 1, 0});
        tbl.push_back('{0, 1, 0, 18'h0,     K_POP,  18'h00020, 1, 1, 0});
        tbl.push_back('{1, 1, 0, 18'h12345, K_PUSH, 18'h0,     2, 1, 0});
        tbl.push_back('{0, 1, 0, 18'h0,     K_POP,  18'h12345, 1, 1, 0});
        tbl.push_back('{0, 1, 0, 18'h0,     K_POP,  18'h00010, 0, 1, 0});
        tbl.push_back('{0, 1, 0, 18'h0,     K_NONE, 18'h0,     0, 1, 1});
        tbl.push_back('{0, 1, 1, 18'h0,     K_NONE, 18'h0,     0, 0, 0});
        tbl.push_back('{0, 1, 0, 18'h0,     K_NONE, 18'h0,     0, 0, 1});
        tbl.push_back('{0, 0, 1, 18'h0,     K_NONE, 18'h0,     0, 0, 0});

        foreach (tbl[i])
            do_op(tbl[i].c, tbl[i].r, tbl[i].clr, tbl[i].a, tbl[i].kind,
                  tbl[i].er, tbl[i].ed, tbl[i].eo, tbl[i].eu);

        // call_req held high: accepted only every other edge, PUSH-cycle requests ignored
        begin
            int pushes = 0;
            int pattern_err = 0;
            wait_ready();
            call_req = 1'b1;
            for (int i = 0; i < 8; i++) begin
                ret_addr_in = 18'h100 + W'(i);
                @(posedge clk);
                @(negedge clk);
                if (stk_wr_en) pushes++;
                if (stk_wr_en != ((i % 2) == 0)) pattern_err++;
            end
            call_req = 1'b0;
            chk("held_pushes", 32'(pushes), 32'd4);
            chk("held_pattern", 32'(pattern_err), 32'd0);
            chk("held_depth", 32'(depth), 32'd4);
            chk("held_overflow", 32'(overflow), 32'd0);
        end
        do_op(0, 1, 0, '0, K_POP, 18'h106, 3, 0, 0);
        do_op(0, 1, 0, '0, K_POP, 18'h104, 2, 0, 0);
        do_op(0, 1, 0, '0, K_POP, 18'h102, 1, 0, 0);
        do_op(0, 1, 0, '0, K_POP, 18'h100, 0, 0, 0);

        // reset landing in WAIT of a pop
        do_op(1, 0, 0, 18'h00055, K_PUSH, '0, 1, 0, 0);
        wait_ready();
        ret_req = 1'b1;
        @(posedge clk);
        #1 ret_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_state_wait", 32'(state_dbg), 32'd3);
        #2 rst = 1'b1;
        #1 chk_reset_vals("midreset");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (ret_valid) seen++;
            end
            chk("post_reset_valid", 32'(seen), 32'd0);
        end
        do_op(0, 1, 0, '0, K_NONE, '0, 0, 0, 1);
        do_op(0, 0, 1, '0, K_NONE, '0, 0, 0, 0);

        // randomized phase against the queue model
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int n = 0; n < 60; n++) begin
            bit           c, r, clr, ovf_set, unf_set;
            logic [W-1:0] a, er;
            int           kind;
            c       = ($urandom_range(0, 99) < 45);
            r       = ($urandom_range(0, 99) < 50);
            clr     = ($urandom_range(0, 99) < 10);
            a       = W'($urandom_range(0, (1 << W) - 1));
            er      = '0;
            kind    = K_NONE;
            ovf_set = 1'b0;
            unf_set = 1'b0;
            if (c) begin
                if (model_stk.size() < 4) begin
                    model_stk.push_back(a);
                    kind = K_PUSH;
                end else begin
                    ovf_set = 1'b1;
                end
            end else if (r) begin
                if (model_stk.size() > 0) begin
                    er   = model_stk.pop_back();
                    kind = K_POP;
                end else begin
                    unf_set = 1'b1;
                end
            end
            m_ovf = clr ? 1'b0 : (m_ovf | ovf_set);
            m_unf = clr ? 1'b0 : (m_unf | unf_set);
            do_op(c, r, clr, a, kind, er, 3'(model_stk.size()), m_ovf, m_unf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
